instruction_fetch_controller: RTL

//   Sequences the single-port instruction memory (1-cycle synchronous read; output held until the next read).

---
 rtl/instruction_fetch_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_controller
// Description : Fetch sequencer for a single-port instruction memory with a
//               1-cycle synchronous read whose output holds until the next
//               read. Holds the PC, issues read requests and presents each
//               fetched word to decode over a valid/ready handshake.
//               Supports start/stop, PC redirect and decode backpressure.
// Optional    : `STOP_AT_END_EN - when defined, fetching ends after the word at
//               address INST_DEPTH-1 is issued (state DONE, o_done raised once
//               that last word is accepted). When undefined the PC wraps and
//               fetching continues; o_done is tied low.
// Ports       : clk, rst_n            clock, asynchronous active-low reset
//               i_start, i_stop       begin fetching / abort to IDLE
//               i_redirect_valid/_pc  load a new PC, drop any in-flight word
//               o_mem_rd_en/_addr     memory read request (address = PC)
//               i_mem_instruction     memory read data
//               o_inst_valid/_data/_pc, i_inst_ready   decode handshake
//               o_busy, o_done        status
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_controller #(
  parameter  int INST_WIDTH = 32,
  parameter  int INST_DEPTH = 16,
  parameter  int RESET_PC   = 0,
  localparam int ADDR_W     = $clog2(INST_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_W-1:0]     i_redirect_pc,
  output logic                  o_mem_rd_en,
  output logic [ADDR_W-1:0]     o_mem_rd_addr,
  input  logic [INST_WIDTH-1:0] i_mem_instruction,
  output logic                  o_inst_valid,
  input  logic                  i_inst_ready,
  output logic [INST_WIDTH-1:0] o_inst_data,
  output logic [ADDR_W-1:0]     o_inst_pc,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(INST_DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_reset_pc  = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] r_inst_pc;
  logic [ADDR_W-1:0] w_inst_pc_nxt;
  logic              r_pending;
  logic              w_pending_nxt;
  logic              w_redirect;
  logic              w_inst_valid;
  logic              w_issue;
  logic              w_handshake;

  // Redirect has no effect in DONE; the final word there is still presented.
  assign w_redirect   = i_redirect_valid && (r_state != S_DONE);
  assign w_inst_valid = r_pending && !w_redirect && !i_stop;
  // A new read is only issued when the memory output register is free to be
  // overwritten, i.e. the currently presented word is absent or being taken.
  assign w_issue      = (r_state == S_RUN) && !i_stop && !i_redirect_valid &&
                        (!w_inst_valid || i_inst_ready);
  assign w_handshake  = w_inst_valid && i_inst_ready;
  // Explicit compare so non-power-of-two depths wrap correctly.
  assign w_pc_inc     = (r_pc == c_last_addr) ? '0 : r_pc + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= c_reset_pc;
      r_inst_pc <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_inst_pc <= w_inst_pc_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_inst_pc_nxt = r_inst_pc;
    w_pending_nxt = r_pending;

    if (w_issue) begin
      w_pc_nxt      = w_pc_inc;
      w_inst_pc_nxt = r_pc;
      w_pending_nxt = 1'b1;
    end else if (w_handshake) begin
      w_pending_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (!i_stop) begin
          if (i_redirect_valid) begin
            w_pc_nxt = i_redirect_pc;
          end
          if (i_start) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
        end else if (i_redirect_valid) begin
          w_pc_nxt = i_redirect_pc;
        end
`ifdef STOP_AT_END_EN
        else if (w_issue && (r_pc == c_last_addr)) begin
          w_state_nxt = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
        end else if (i_start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = c_reset_pc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // stop and redirect both discard the word in flight.
    if (i_stop || w_redirect) begin
      w_pending_nxt = 1'b0;
    end
  end

  assign o_mem_rd_en   = w_issue;
  assign o_mem_rd_addr = r_pc;
  assign o_inst_valid  = w_inst_valid;
  assign o_inst_data   = i_mem_instruction;
  assign o_inst_pc     = r_inst_pc;
  assign o_busy        = (r_state != S_IDLE);
`ifdef STOP_AT_END_EN
  assign o_done        = (r_state == S_DONE) && !r_pending;
`else
  assign o_done        = 1'b0;
`endif

endmodule
`default_nettype wire
